// File: rtl/chaotic_lmap.sv
// Fixed-point logistic-map step: xtnext = r * xt * (1 - xt), Q0.16 state, integer gain,
// truncated result with saturation to 16'hFFFF once the product reaches 1.0.
module chaotic_lmap (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] xt,
   input  logic [7:0]  r,
   output logic [15:0] xtnext
);

   logic [16:0] c;
   logic [32:0] p;
   logic [40:0] q;
   logic        sat;
   logic [15:0] result;

   // c spans [1, 65536], so it needs the 17th bit to represent xt = 0 exactly.
   always_comb begin
      c      = 17'h1_0000 - {1'b0, xt};
      p      = 33'(xt) * 33'(c);
      q      = 41'(p) * 41'(r);
      sat    = |q[40:32];
      result = sat ? 16'hFFFF : q[31:16];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) xtnext <= 16'h0000;
      else          xtnext <= result;
   end

endmodule

// File: tb/tb_chaotic_lmap.sv
// Directed bench for chaotic_lmap: reset, closed-loop orbit, truncation, saturation,
// gain edge cases and mid-orbit reset, all against hand-computed values.
module tb_chaotic_lmap;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] xt      = 16'd0;
   logic [7:0]  r       = 8'd0;
   logic [15:0] xtnext;

   int pass_cnt  = 0;
   int total_cnt = 0;

   chaotic_lmap dut (
      .clock   (clock),
      .reset_n (reset_n),
      .xt      (xt),
      .r       (r),
      .xtnext  (xtnext)
   );

   always #5 clock = ~clock;

   // Present one input pair, take one edge, sample 1 time unit later.
   task automatic step(input logic [15:0] x, input logic [7:0] g, input logic [15:0] exp,
                       input string name);
      xt = x;
      r  = g;
      @(posedge clock);
      #1;
      total_cnt++;
      if (xtnext !== exp)
         $display("FAIL %s: xt=%0d r=%0d got %0d expected %0d", name, x, g, xtnext, exp);
      else
         pass_cnt++;
   endtask

   task automatic test_reset();
      xt = 16'd3000;
      r  = 8'd4;
      #1 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (xtnext !== 16'h0000) $display("FAIL reset_async: got %0h expected 0", xtnext);
      else pass_cnt++;
      @(posedge clock);
      #1;
      total_cnt++;
      if (xtnext !== 16'h0000) $display("FAIL reset_hold: got %0h expected 0", xtnext);
      else pass_cnt++;
      @(negedge clock);
      reset_n = 1'b1;
      step(16'd3000, 8'd4, 16'd11450, "reset_release");
   endtask

   task automatic test_orbit();
      logic [15:0] exp_orbit [5];
      logic [15:0] cur;
      exp_orbit = '{16'd11450, 16'd37798, 16'd63991, 16'd6034, 16'd21913};
      cur = 16'd3000;
      for (int i = 0; i < 5; i++) begin
         step(cur, 8'd4, exp_orbit[i], $sformatf("orbit_%0d", i));
         cur = xtnext;
      end
   endtask

   task automatic test_truncation();
      step(16'd12,   8'd4, 16'd47,    "small_seed");
      step(16'd3000, 8'd5, 16'd14313, "gain5_trunc");
   endtask

   task automatic test_saturation();
      step(16'd32768, 8'd4,   16'hFFFF, "sat_half_r4");
      step(16'd65535, 8'd4,   16'd3,    "near_one_r4");
      step(16'd3000,  8'd255, 16'hFFFF, "sat_r255");
   endtask

   task automatic test_gain_edges();
      step(16'd3000,  8'd0,   16'd0,     "r0_a");
      step(16'd32768, 8'd0,   16'd0,     "r0_b");
      step(16'd32768, 8'd2,   16'd32768, "r2_fixed_point");
      step(16'd32768, 8'd3,   16'd49152, "r3_half");
      step(16'd0,     8'd255, 16'd0,     "x0_r255");
   endtask

   task automatic test_back_to_back();
      // Inputs changed between edges must not disturb the held output.
      step(16'd3000, 8'd4, 16'd11450, "b2b_first");
      xt = 16'd12;
      #2;
      total_cnt++;
      if (xtnext !== 16'd11450) $display("FAIL b2b_hold: got %0d expected 11450", xtnext);
      else pass_cnt++;
      step(16'd11450, 8'd4, 16'd37798, "b2b_second");
   endtask

   task automatic test_reset_mid_run();
      step(16'd3000,  8'd4, 16'd11450, "mid_pre0");
      step(xtnext,    8'd4, 16'd37798, "mid_pre1");
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (xtnext !== 16'h0000) $display("FAIL mid_reset_async: got %0d expected 0", xtnext);
      else pass_cnt++;
      @(negedge clock);
      reset_n = 1'b1;
      step(16'd3000, 8'd4, 16'd11450, "mid_reseed");
   endtask

   initial begin
      test_reset();
      test_orbit();
      test_truncation();
      test_saturation();
      test_gain_edges();
      test_back_to_back();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
